// File: rtl/set_bit_serializer_pkg.sv
// Shared types and helpers for the set-bit serializer.
package set_bit_serializer_pkg;

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int MAX_W = 64;

    // Binary position of a one-hot value; callers zero-extend to MAX_W and truncate the result.
    function automatic logic [31:0] onehot_to_idx(input logic [MAX_W-1:0] onehot);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (onehot[i]) idx = idx | 32'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/set_bit_serializer_bit_pick.sv
// Combinational priority pick: isolates the rightmost or leftmost set bit of rem_i.
module set_bit_serializer_bit_pick
    import set_bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter bit LSB_FIRST = 1'b1,
    parameter int IDX_W     = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] rem_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             single_o
);

    logic [WIDTH-1:0] rev;
    logic [WIDTH-1:0] rev_iso;

    // Leftmost pick reuses the x & -x trick on the bit-reversed word.
    always_comb begin
        rev      = '0;
        rev_iso  = '0;
        onehot_o = '0;
        if (LSB_FIRST) begin
            onehot_o = rem_i & (~rem_i + WIDTH'(1));
        end else begin
            for (int i = 0; i < WIDTH; i++) rev[i] = rem_i[WIDTH-1-i];
            rev_iso = rev & (~rev + WIDTH'(1));
            for (int i = 0; i < WIDTH; i++) onehot_o[i] = rev_iso[WIDTH-1-i];
        end
    end

    assign idx_o    = IDX_W'(onehot_to_idx(MAX_W'(onehot_o)));
    assign single_o = (rem_i != '0) && ((rem_i & (rem_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/set_bit_serializer.sv
// Accepts a word per handshake and emits the position of each set bit, one beat per cycle.
module set_bit_serializer
    import set_bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter bit LSB_FIRST = 1'b1,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic             idx_val_o,
    output logic             idx_last_o,
    input  logic             idx_ready_i,
    output logic             zero_o
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_single;
    logic             busy, accept, beat_done;

    set_bit_serializer_bit_pick #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_bit_pick (
        .rem_i    (rem_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .single_o (pick_single)
    );

    assign busy         = (state_q == BUSY);
    assign idx_val_o    = busy;
    assign onehot_o     = busy ? pick_onehot : '0;
    assign idx_o        = busy ? pick_idx    : '0;
    assign idx_last_o   = busy && pick_single;
    assign data_ready_o = !busy || (idx_last_o && idx_ready_i);
    assign zero_o       = zero_q;

    assign accept    = data_val_i && data_ready_o;
    assign beat_done = idx_val_o && idx_ready_i;

    // NOTE: every _d gets a default first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        zero_d  = 1'b0;
        if (accept) begin
            // Also covers the last beat of a word meeting a new word in the same cycle.
            if (data_i != '0) begin
                rem_d   = data_i;
                state_d = BUSY;
            end else begin
                rem_d   = '0;
                state_d = IDLE;
                zero_d  = 1'b1;
            end
        end else if (beat_done) begin
            rem_d = rem_q & ~pick_onehot;
            if (pick_single) state_d = IDLE;
        end
    end

    // NOTE: state is updated with non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: doc/set_bit_serializer.md
Name: set_bit_serializer

Overview:
Downstream stage of the priority encoder path. Accepts one WIDTH-bit word per valid/ready handshake and emits the positions of all its set bits, one per beat. Each beat carries the binary index, the one-hot mask and a last flag. Selection is priority-encoded: each beat picks the rightmost or leftmost remaining bit, then clears it. The block feeds per-bit consumers such as request servicing or interrupt dispatch.

Parameters:
WIDTH, 5, input word width; must be >= 2
LSB_FIRST, 1, 1 = emit rightmost set bit first, 0 = emit leftmost set bit first
IDX_W, $clog2(WIDTH), width of index output; derived, not overridden

Ports:
clk_i  input  1  single clock; all logic on rising edge
srst_i  input  1  synchronous reset, active-high
data_i  input  WIDTH  word to serialize
data_val_i  input  1  data_i valid
data_ready_o  output  1  block can accept data_i this cycle
idx_o  output  IDX_W  binary index of the current set bit
onehot_o  output  WIDTH  one-hot mask of the current set bit
idx_val_o  output  1  idx_o/onehot_o/idx_last_o valid
idx_last_o  output  1  current beat is the final set bit of the word
idx_ready_i  input  1  downstream accepts the beat
zero_o  output  1  one-cycle pulse: an all-zero word was accepted

Behaviour:
- Interface: one clock (clk_i); synchronous active-high reset (srst_i).
- Internal state: shadow register rem[WIDTH] holds the remaining bits. FSM states are IDLE and BUSY.
- Reset (srst_i=1 at a clock edge):
  - state=IDLE, rem=0, zero_o=0.
  - Outputs after reset: idx_val_o=0, idx_o=0, onehot_o=0, idx_last_o=0, data_ready_o=1.
  - Reset mid-word discards the remaining bits. There is no final beat.
- data_ready_o is combinational: IDLE, or (BUSY and idx_val_o and idx_last_o and idx_ready_i).
- Accept: data_val_i & data_ready_o at a clock edge.
  - Nonzero data_i: rem<=data_i, state<=BUSY.
  - Zero data_i: zero_o<=1 for exactly one cycle, state stays/returns IDLE, no beat is emitted.
- BUSY outputs are combinational from rem:
  - idx_val_o=1.
  - onehot_o = rightmost set bit of rem (rem & -rem) if LSB_FIRST, else leftmost set bit.
  - idx_o = binary position of onehot_o.
  - idx_last_o = 1 iff rem has exactly one bit set.
- IDLE outputs: idx_val_o=0, onehot_o=0, idx_o=0, idx_last_o=0.
- Latency: first beat is valid in the cycle after accept. Throughput is one beat per cycle while idx_ready_i=1.
- Handshake:
  - A beat completes on idx_val_o & idx_ready_i.
  - On completion, rem <= rem & ~onehot_o.
  - If idx_last_o, state<=IDLE unless a new word is accepted in the same cycle.
  - On a last beat with a simultaneous new accept, load rem from data_i and stay BUSY (zero-bubble back-to-back). A simultaneous zero word returns to IDLE and pulses zero_o.
- Backpressure: while idx_ready_i=0, rem, idx_o, onehot_o and idx_last_o hold stable and idx_val_o stays 1. A valid beat is never withdrawn.
- Ignored input: data_i and data_val_i are ignored when data_ready_o=0.
- Word with all bits set (WIDTH bits): exactly WIDTH beats; idx_last_o only on the WIDTH-th beat.
- Beat count per word equals popcount(data_i). Indices are strictly increasing (LSB_FIRST=1) or decreasing (LSB_FIRST=0).

Decomposition:
- Package set_bit_serializer_pkg:
  - typedef enum logic {IDLE, BUSY} state_t.
  - Function onehot_to_idx(onehot), parameterized via the WIDTH argument size.
- One natural sub-module: bit_pick, combinational. Given rem and LSB_FIRST, it returns onehot_o, idx_o and the single-bit flag. The top holds only the FSM and rem.

Test Plan:
- WIDTH=5, LSB_FIRST=1, data_i=5'b10110, idx_ready_i=1 -> cycles +1..+3 give idx_o=1,2,4; onehot_o=00010,00100,10000; idx_last_o only on idx 4; data_ready_o=0 on beats 1-2.
- Same word, LSB_FIRST=0 -> idx_o=4,2,1; last on idx 1.
- data_i=5'b01001, idx_ready_i low for 3 cycles on the first beat -> idx_o=0 held stable 3 cycles, then idx_o=3 with last; no beat lost or duplicated.
- data_i=0 accepted -> zero_o=1 for one cycle, idx_val_o stays 0, data_ready_o stays 1.
- Back-to-back: 5'b00001 then 5'b11111 held valid -> second word accepted on the last beat of the first; idx_o sequence 0,0,1,2,3,4 with no idle cycle; last on beats 1 and 6.
- srst_i=1 after the first beat of 5'b11111 -> next cycle idx_val_o=0, data_ready_o=1; word 5'b00100 then yields a single beat idx_o=2 with last.
